multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state FETCH immediately.
REQ-004 op  input  7  opcode field, instruction register bits [6:0].
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU result equals zero.
REQ-008 PCWrite  output  1  PC register enable.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-010 MemWrite  output  1  memory write enable.
REQ-011 IRWrite  output  1  instruction and OldPC register enable.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-014 ALUSrcA  output  2  SrcA select: 00=PC, 01=OldPC, 10=rs1.
REQ-015 ALUSrcB  output  2  SrcB select: 00=rs2, 01=ImmExt, 10=constant 4.
REQ-016 ImmSrc  output  2  immediate type: 00=I, 01=S, 10=B, 11=J.
REQ-017 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 state  output  4  current state code, debug and bench observation.

Function
REQ-019 A Moore FSM SHALL hold 11 states, encoded 0-10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-020 Transitions SHALL be: FETCH->DECODE.
REQ-021 DECODE SHALL go to MEMADR (op 0000011/0100011), EXECUTER (0110011), EXECUTEI (0010011), JAL (1101111) or BEQ (1100011).
REQ-022 DECODE SHALL go to FETCH for any other op; no write enable asserts for that instruction.
REQ-023 MEMADR SHALL go to MEMREAD if op=0000011, else MEMWRITE.
REQ-024 MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BEQ->FETCH.
REQ-025 Per-state outputs SHALL be as follows; unlisted signals are 0.
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-026 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally.
REQ-027 ImmSrc SHALL decode from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-028 ALUControl SHALL decode ALUOp/funct3/op[5]/funct7 as follows:
- ALUOp 00->000; ALUOp 01->001.
- ALUOp 10, funct3 000: 001 if op[5]&funct7, else 000.
- ALUOp 10, funct3 010->101; 110->011; 111->010.
- Any other funct3->000.
REQ-029 Instruction latencies SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-030 While reset=1, state SHALL be FETCH, and PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0.
REQ-031 While reset=1, all other outputs SHALL show FETCH values.
REQ-032 Reset asserted mid-instruction SHALL abandon it with no further write enables; the first edge after deassertion performs FETCH.

Structure
REQ-033 A shared package riscv_mc_pkg SHALL hold:
- state encodings and opcode constants;
- ALUControl, ALUOp, ResultSrc, ALUSrcA/B and ImmSrc codes.
REQ-034 ALU decoding SHALL be one sub-module, alu_decoder (inputs ALUOp, funct3, op[5], funct7; output ALUControl).
REQ-035 The state register SHALL be the only sequential element.

Verification
REQ-036 Reset pulse mid-MEMREAD -> state=0 asynchronously, all write enables 0; after release, IRWrite=1 in the next cycle.
REQ-037 add (op 0110011, funct3 000, funct7 0) -> states 0,1,6,8,0; ALUControl 000 in EXECUTER; RegWrite=1 only in ALUWB. With funct7=1 (sub) -> ALUControl 001.
REQ-038 lw (op 0000011) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB; ImmSrc=00.
REQ-039 sw (op 0100011) -> states 0,1,2,5,0; MemWrite=1 only in MEMWRITE; ImmSrc=01.
REQ-040 beq with Zero=1 -> PCWrite=1 in BEQ, ALUControl 001; with Zero=0 -> PCWrite=0; ImmSrc=10.
REQ-041 Illegal op 0000000 -> states 0,1,0; no RegWrite/MemWrite pulse.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes and datapath select / ALU codes.
package riscv_mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, independent of state.
    function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            default:  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields to an ALU operation.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [SEL_W-1:0]    alu_op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                op5,
    input  logic                funct7,
    output logic [ALUCTL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can encode sub; addi ignores funct7.
                    3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multicycle RISC-V core; the state register
// is the only storage, all control outputs decode from state and opcode.
module multicycle_control_unit
    import riscv_mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7,
    input  logic                Zero,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [STATE_W-1:0]  state
);

    state_e           state_q;
    state_e           state_d;
    logic             pc_update;
    logic             branch;
    logic             mem_write_s;
    logic             ir_write_s;
    logic             reg_write_s;
    logic [SEL_W-1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d     = state_q;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are held off for as long as reset is asserted.
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write_s;
    assign RegWrite = ~reset & reg_write_s;
    assign MemWrite = ~reset & mem_write_s;
    assign ImmSrc   = imm_src_of(op);
    assign state    = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7      (funct7),
        .alu_control (ALUControl)
    );

endmodule
